reg_dest_queue: RTL and testbench
=================================

# reg_dest_queue

Parametrised successor to the register-destination multiplexer in the multicycle MIPS datapath. It selects the write-back destination register from a `reg_dest` code and enqueues it in an in-order queue of pending writes. It exposes the oldest pending destination to the write-back stage and reports whether two queried source registers still have a write outstanding. The block sits between instruction decode and the register-file write port, so long-latency operations (mult/div, loads) can be tracked without stalling decode.

## Interface
Parameters:
- `ADDR_W`, 5: register-address width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RA_REG`, 31: destination for code 010 (jal link).
- `SP_REG`, 29: destination for code 011 (stack pointer).

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `reg_dest`  in  3: destination select code.
- `instr_rt`  in  ADDR_W: instruction rt field.
- `instr_rd`  in  ADDR_W: instruction rd field.
- `instr_rs`  in  ADDR_W: instruction rs field.
- `issue_valid`  in  1: request to enqueue the selected destination.
- `issue_ready`  out  1: queue can accept; equals !full.
- `dest_sel`  out  ADDR_W: combinational selected destination. 0 for illegal codes.
- `commit`  in  1: write-back of the head entry completes this cycle.
- `wb_valid`  out  1: queue non-empty.
- `wb_dest`  out  ADDR_W: head entry. 0 when empty.
- `src_a`, `src_b`  in  ADDR_W: source registers to check.
- `src_a_busy`, `src_b_busy`  out  1: a queued entry matches the source.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `err_illegal`  out  1: sticky; an illegal code was issued.
- `err_underflow`  out  1: sticky; commit was asserted while the queue was empty.

## Operation
- Code map:
  - 000 → `instr_rt`
  - 001 → `instr_rd`
  - 010 → `RA_REG`
  - 011 → `SP_REG`
  - 100 → `instr_rs`
  - 101–111 → illegal.
- An issue is accepted when `issue_valid && issue_ready`.
  - Legal code with nonzero destination: the destination is written at the tail, the tail pointer advances, and count increments.
  - Legal code with destination 0: accepted but not enqueued, because writes to `$zero` are discarded.
  - Illegal code: not enqueued; `err_illegal` is set.
- `issue_valid` while full: ignored. Queue state is unchanged and no error is raised.
- Commit with `wb_valid`: the head pointer advances and count decrements.
- Commit while empty: ignored; `err_underflow` is set.
- Simultaneous accepted enqueue and commit: both pointers advance and count is unchanged. This is legal at any non-empty, non-full occupancy.
- Enqueue while full is never accepted, even with a same-cycle commit. `issue_ready` is strictly !full, with no bypass.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count saturates by construction at 0 and DEPTH.
- Busy checks:
  - `src_x_busy` is the OR over valid entries of (entry == `src_x`).
  - It is forced to 0 when `src_x` == 0.
  - Duplicate destinations in the queue are allowed. Busy stays high until the last matching entry commits.
- Error flags clear only on `reset`.

## Timing
- `reset` (synchronous) clears pointers, count, valid bits and both error flags on the next edge.
  - After reset: `wb_valid`=0, `wb_dest`=0, `issue_ready`=1, busy flags=0, `count`=0.
  - Reset overrides a same-cycle issue or commit. Those requests are dropped.
- `dest_sel` is combinational from `reg_dest` and the instruction fields, with zero latency.
- Enqueue latency is 1 cycle. The entry is visible in `wb_dest`, `count` and the busy flags in the cycle after the accepting edge. The same-cycle issued destination does not assert busy.
- Commit takes effect at the edge. The entry stops contributing to busy in the following cycle, so busy remains asserted during the commit cycle.
- `issue_ready`, `wb_valid`, `wb_dest`, busy flags and `count` are combinational from registered state only. None depend on `issue_valid` or `commit`.

## Test plan
- Reset, then issue code 001 with rd=8 → next cycle: `wb_valid`=1, `wb_dest`=8, `count`=1; `src_a`=8 gives busy=1. Commit → `count`=0 and busy=0 the cycle after.
- Issue codes 010, 011, 100 (rs=5), 000 (rt=0) in sequence → queue holds 31, 29, 5; `count`=3; rt=0 was accepted with no entry. Commit three times → `wb_dest` reads 31, 29, 5 in order.
- Fill with 4 entries (DEPTH=4) → `issue_ready`=0. Issue plus commit in the same cycle → issue dropped, `count`=3. Then issue again → `count`=4. Pointers wrap correctly over 10 fill/drain rounds.
- At `count`=2, issue rd=12 together with commit → `count` stays 2; head advances; 12 is at the tail.
- Issue code 110 → nothing enqueued, `err_illegal`=1. Commit while empty → `err_underflow`=1. Both flags persist until `reset`.
- Queue two entries with dest 9 → `src_b`=9 busy stays 1 after the first commit and drops after the second. Assert `reset` mid-operation with a same-cycle issue → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/reg_dest_queue.sv
// Register-destination select plus an in-order queue of pending register-file writes.
// Exposes the oldest pending destination and flags sources that still have a write in flight.
module reg_dest_queue #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RA_REG = 31,
    parameter int unsigned SP_REG = 29
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               reg_dest,
    input  logic [ADDR_W-1:0]        instr_rt,
    input  logic [ADDR_W-1:0]        instr_rd,
    input  logic [ADDR_W-1:0]        instr_rs,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    output logic [ADDR_W-1:0]        dest_sel,
    input  logic                     commit,
    output logic                     wb_valid,
    output logic [ADDR_W-1:0]        wb_dest,
    input  logic [ADDR_W-1:0]        src_a,
    input  logic [ADDR_W-1:0]        src_b,
    output logic                     src_a_busy,
    output logic                     src_b_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_illegal,
    output logic                     err_underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_underflow_q, err_underflow_d;

    logic code_legal;
    logic full;
    logic empty;
    logic accept;
    logic enq;
    logic deq;

    // Destination decode; illegal codes yield register 0.
    always_comb begin
        dest_sel   = '0;
        code_legal = 1'b1;
        case (reg_dest)
            3'b000:  dest_sel = instr_rt;
            3'b001:  dest_sel = instr_rd;
            3'b010:  dest_sel = ADDR_W'(RA_REG);
            3'b011:  dest_sel = ADDR_W'(SP_REG);
            3'b100:  dest_sel = instr_rs;
            default: code_legal = 1'b0;
        endcase
    end

    assign full   = (count_q == CntW'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = issue_valid && !full && !reset;
    // Writes to $zero are accepted but never tracked.
    assign enq    = accept && code_legal && (dest_sel != '0);
    assign deq    = commit && !empty && !reset;

    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        valid_d         = valid_q;
        err_illegal_d   = err_illegal_q | (accept && !code_legal);
        err_underflow_d = err_underflow_q | (commit && empty);

        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PtrW'(1);
        end
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PtrW'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            valid_q         <= '0;
            err_illegal_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            valid_q         <= valid_d;
            err_illegal_q   <= err_illegal_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Payload storage needs no reset; valid bits and wb_valid gate every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= dest_sel;
        end
    end

    always_comb begin
        src_a_busy = 1'b0;
        src_b_busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i] == src_a)) begin
                src_a_busy = 1'b1;
            end
            if (valid_q[i] && (mem_q[i] == src_b)) begin
                src_b_busy = 1'b1;
            end
        end
        if (src_a == '0) begin
            src_a_busy = 1'b0;
        end
        if (src_b == '0) begin
            src_b_busy = 1'b0;
        end
    end

    assign issue_ready   = !full;
    assign wb_valid      = !empty;
    assign wb_dest       = empty ? '0 : mem_q[head_q];
    assign count         = count_q;
    assign err_illegal   = err_illegal_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_dest_queue.sv
// Scoreboard bench for reg_dest_queue: expected destinations are queued on issue and
// compared against wb_dest as each head entry commits.
module tb_reg_dest_queue;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        reg_dest;
    logic [ADDR_W-1:0] instr_rt, instr_rd, instr_rs;
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] dest_sel;
    logic              commit;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dest;
    logic [ADDR_W-1:0] src_a, src_b;
    logic              src_a_busy, src_b_busy;
    logic [$clog2(DEPTH):0] count;
    logic              err_illegal, err_underflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [ADDR_W-1:0] sb [$];
    logic              m_err_ill;
    logic              m_err_uf;

    always #5 clk = ~clk;

    reg_dest_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RA_REG (31),
        .SP_REG (29)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .reg_dest      (reg_dest),
        .instr_rt      (instr_rt),
        .instr_rd      (instr_rd),
        .instr_rs      (instr_rs),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .dest_sel      (dest_sel),
        .commit        (commit),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .src_a         (src_a),
        .src_b         (src_b),
        .src_a_busy    (src_a_busy),
        .src_b_busy    (src_b_busy),
        .count         (count),
        .err_illegal   (err_illegal),
        .err_underflow (err_underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] model_sel(input logic [2:0] code,
                                                    input logic [ADDR_W-1:0] rt,
                                                    input logic [ADDR_W-1:0] rd,
                                                    input logic [ADDR_W-1:0] rs);
        case (code)
            3'd0:    return rt;
            3'd1:    return rd;
            3'd2:    return 5'd31;
            3'd3:    return 5'd29;
            3'd4:    return rs;
            default: return '0;
        endcase
    endfunction

    function automatic logic model_busy(input logic [ADDR_W-1:0] src);
        if (src == '0) return 1'b0;
        foreach (sb[i]) begin
            if (sb[i] == src) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_state();
        check_eq("count", 32'(count), 32'(sb.size()));
        check_eq("wb_valid", 32'(wb_valid), 32'(sb.size() != 0));
        check_eq("wb_dest", 32'(wb_dest), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
        check_eq("issue_ready", 32'(issue_ready), 32'(sb.size() != DEPTH));
        check_eq("err_illegal", 32'(err_illegal), 32'(m_err_ill));
        check_eq("err_underflow", 32'(err_underflow), 32'(m_err_uf));
        check_eq("busy_a", 32'(src_a_busy), 32'(model_busy(src_a)));
        check_eq("busy_b", 32'(src_b_busy), 32'(model_busy(src_b)));
    endtask

    task automatic set_issue(input logic [2:0] code, input logic [ADDR_W-1:0] rt,
                             input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs);
        issue_valid = 1'b1;
        reg_dest    = code;
        instr_rt    = rt;
        instr_rd    = rd;
        instr_rs    = rs;
    endtask

    // One clock: pre-edge combinational checks, model update, post-edge state checks.
    task automatic tick(input logic cm, input logic rst);
        logic [ADDR_W-1:0] sel;
        logic              full_b;
        commit = cm;
        reset  = rst;
        #1;
        sel    = model_sel(reg_dest, instr_rt, instr_rd, instr_rs);
        full_b = (sb.size() == DEPTH);
        check_eq("dest_sel", 32'(dest_sel), 32'(sel));
        check_eq("busy_a_pre", 32'(src_a_busy), 32'(model_busy(src_a)));
        check_eq("busy_b_pre", 32'(src_b_busy), 32'(model_busy(src_b)));
        check_eq("ready_pre", 32'(issue_ready), 32'(!full_b));
        if (rst) begin
            sb.delete();
            m_err_ill = 1'b0;
            m_err_uf  = 1'b0;
        end else begin
            if (cm) begin
                if (sb.size() != 0) check_eq("wb_dest_pop", 32'(wb_dest), 32'(sb.pop_front()));
                else m_err_uf = 1'b1;
            end
            if (issue_valid && !full_b) begin
                if (reg_dest > 3'd4) m_err_ill = 1'b1;
                else if (sel != '0) sb.push_back(sel);
            end
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        commit      = 1'b0;
        reset       = 1'b0;
        check_state();
    endtask

    task automatic drain();
        while (sb.size() != 0) tick(1'b1, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        commit      = 1'b0;
        reg_dest    = 3'd0;
        instr_rt    = '0;
        instr_rd    = '0;
        instr_rs    = '0;
        src_a       = '0;
        src_b       = '0;
        m_err_ill   = 1'b0;
        m_err_uf    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state();

        // Single rd issue, then commit.
        src_a = 5'd8;
        set_issue(3'b001, 5'd0, 5'd8, 5'd0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);

        // Fixed-register and rs codes; rt=0 accepted without an entry.
        set_issue(3'b010, 5'd3, 5'd4, 5'd5); tick(1'b0, 1'b0);
        set_issue(3'b011, 5'd3, 5'd4, 5'd5); tick(1'b0, 1'b0);
        set_issue(3'b100, 5'd3, 5'd4, 5'd5); tick(1'b0, 1'b0);
        set_issue(3'b000, 5'd0, 5'd4, 5'd5); tick(1'b0, 1'b0);
        check_eq("count_after_rt0", 32'(count), 32'd3);
        drain();

        // Full queue: issue with same-cycle commit is dropped.
        for (int k = 1; k <= 4; k++) begin
            set_issue(3'b001, 5'd0, 5'(k), 5'd0);
            tick(1'b0, 1'b0);
        end
        set_issue(3'b001, 5'd0, 5'd7, 5'd0);
        tick(1'b1, 1'b0);
        check_eq("count_full_drop", 32'(count), 32'd3);
        set_issue(3'b001, 5'd0, 5'd7, 5'd0);
        tick(1'b0, 1'b0);
        check_eq("count_refill", 32'(count), 32'd4);
        drain();

        // Pointer wrap over repeated fill/drain rounds.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                set_issue(3'b001, 5'd0, 5'($urandom_range(1, 31)), 5'd0);
                tick(1'b0, 1'b0);
            end
            drain();
        end

        // Simultaneous issue and commit at count 2.
        set_issue(3'b001, 5'd0, 5'd20, 5'd0); tick(1'b0, 1'b0);
        set_issue(3'b001, 5'd0, 5'd21, 5'd0); tick(1'b0, 1'b0);
        set_issue(3'b001, 5'd0, 5'd12, 5'd0); tick(1'b1, 1'b0);
        check_eq("count_simul", 32'(count), 32'd2);
        check_eq("head_simul", 32'(wb_dest), 32'd21);
        drain();

        // Sticky error flags.
        set_issue(3'b110, 5'd1, 5'd2, 5'd3); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check_eq("err_ill_sticky", 32'(err_illegal), 32'd1);
        check_eq("err_uf_sticky", 32'(err_underflow), 32'd1);

        // Duplicate destinations keep busy until the last one commits.
        src_b = 5'd9;
        set_issue(3'b001, 5'd0, 5'd9, 5'd0); tick(1'b0, 1'b0);
        set_issue(3'b000, 5'd9, 5'd0, 5'd0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("dup_busy_one_left", 32'(src_b_busy), 32'd1);
        tick(1'b1, 1'b0);
        check_eq("dup_busy_cleared", 32'(src_b_busy), 32'd0);

        // Reset mid-operation overrides a same-cycle issue.
        set_issue(3'b001, 5'd0, 5'd3, 5'd0); tick(1'b0, 1'b0);
        set_issue(3'b001, 5'd0, 5'd4, 5'd0); tick(1'b0, 1'b1);

        // Random traffic with small register values to provoke busy hits.
        for (int n = 0; n < 120; n++) begin
            src_a = 5'($urandom_range(0, 7));
            src_b = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                set_issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
            tick(1'($urandom_range(0, 1)), 1'b0);
        end
        set_issue(3'b001, 5'd0, 5'd5, 5'd0);
        tick(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
